// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Fixed 640x480@60 Hz raster constants, the video control bundle type that
// travels down the fetch-latency pipeline, and the coordinate decoder.
// Contents:
//   H_*/V_* constants      : visible, porch, sync and total sizes
//   *_SYNC_FIRST/LAST      : inclusive sync windows derived from the sizes
//   vga_ctrl_t             : {hs_n, vs_n, blank_n}
//   CTRL_IDLE              : inactive control value (hs_n=1, vs_n=1, blank_n=0)
//   decode_ctrl()          : control bundle for a given (x, y)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_FIRST = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_FIRST = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 10'd1;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic blank_n;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0};

  // Sync pulses are active low; blank_n is high only inside the visible area.
  function automatic vga_ctrl_t decode_ctrl(input logic [9:0] x, input logic [9:0] y);
    vga_ctrl_t c;
    c.hs_n    = !((x >= H_SYNC_FIRST) && (x <= H_SYNC_LAST));
    c.vs_n    = !((y >= V_SYNC_FIRST) && (y <= V_SYNC_LAST));
    c.blank_n = (x < H_VISIBLE) && (y < V_VISIBLE);
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// ---------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage register pipeline for the video control bundle. Stage 0 is the
// decode register; the output is the last stage, so a value presented on
// i_ctrl in cycle t appears on o_ctrl in cycle t+DEPTH.
// Parameters: DEPTH (1..8)
// Ports:
//   i_clk     : pixel clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_rst_val : value every stage takes during reset
//   i_ctrl    : combinational decode of the current coordinates
//   o_ctrl    : delayed control bundle
// ---------------------------------------------------------------------------
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  vga_ctrl_t i_rst_val,
  input  vga_ctrl_t i_ctrl,
  output vga_ctrl_t o_ctrl
);

  vga_ctrl_t r_stage [DEPTH];

  // Shift pipeline; all stages go inactive on reset so nothing stale is shown.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= i_rst_val;
      end
    end else begin
      r_stage[0] <= i_ctrl;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_ctrl = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 Hz raster timing generator. DrawX/DrawY and the LINE_END /
// FRAME_END strobes are aligned with each other; VGA_HS/VGA_VS/VGA_BLANK_N
// lag them by FETCH_LATENCY cycles to match the frame buffer read path.
// Optional feature macro: VGA_FRAME_COUNT_EN (enables FRAME_COUNT counter;
// when undefined FRAME_COUNT is tied to 0).
// Parameters: FETCH_LATENCY (1..8, default 2)
// Ports:
//   VGA_CLK     : 25 MHz pixel clock
//   RESET_N     : asynchronous active-low reset
//   DrawX       : horizontal count 0..799
//   DrawY       : vertical count 0..524
//   FRAME_END   : high while (DrawX, DrawY) = (799, 524)
//   LINE_END    : high while DrawX = 799
//   VGA_HS      : horizontal sync, active low, delayed
//   VGA_VS      : vertical sync, active low, delayed
//   VGA_BLANK_N : high in visible region, delayed
//   FRAME_COUNT : completed frames (16-bit wrapping)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int FETCH_LATENCY = 2
) (
  input  logic        VGA_CLK,
  input  logic        RESET_N,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        FRAME_END,
  output logic        LINE_END,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [15:0] FRAME_COUNT
);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       w_line_end;
  logic       w_frame_end;
  vga_ctrl_t  w_ctrl;
  vga_ctrl_t  w_ctrl_dly;

  assign w_line_end  = (r_x == H_LAST);
  assign w_frame_end = w_line_end && (r_y == V_LAST);

  // Horizontal counter: every cycle, wrapping at end of line.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_x <= 10'd0;
    end else if (w_line_end) begin
      r_x <= 10'd0;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  // Vertical counter: advances only on the horizontal wrap.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_y <= 10'd0;
    end else if (w_frame_end) begin
      r_y <= 10'd0;
    end else if (w_line_end) begin
      r_y <= r_y + 10'd1;
    end else begin
      r_y <= r_y;
    end
  end

  assign w_ctrl = decode_ctrl(r_x, r_y);

  // The decode register is the first pipeline stage, so total lag is DEPTH.
  sync_delay_line #(
    .DEPTH(FETCH_LATENCY)
  ) u_sync_delay_line (
    .i_clk     (VGA_CLK),
    .i_rst_n   (RESET_N),
    .i_rst_val (CTRL_IDLE),
    .i_ctrl    (w_ctrl),
    .o_ctrl    (w_ctrl_dly)
  );

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Completed-frame counter, wrapping naturally at 16 bits.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_count <= 16'd0;
    end else if (w_frame_end) begin
      r_frame_count <= r_frame_count + 16'd1;
    end else begin
      r_frame_count <= r_frame_count;
    end
  end

  assign FRAME_COUNT = r_frame_count;
`else
  assign FRAME_COUNT = 16'd0;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign LINE_END    = w_line_end;
  assign FRAME_END   = w_frame_end;
  assign VGA_HS      = w_ctrl_dly.hs_n;
  assign VGA_VS      = w_ctrl_dly.vs_n;
  assign VGA_BLANK_N = w_ctrl_dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock and reset: dut (FETCH_LATENCY=2) and dut8
// (FETCH_LATENCY=8). A table of hand-computed checkpoints covers the first
// lines after reset; hand-written sequences cover mid-frame reset, the frame
// wrap and the frame counter. The vertical counter is forced forward to keep
// the run short.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x2, y2, x8, y8;
  logic        fe2, le2, hs2, vs2, bl2, fe8, le8, hs8, vs8, bl8;
  logic [15:0] fc2, fc8;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_gen #(.FETCH_LATENCY(2)) dut (
    .VGA_CLK(clk), .RESET_N(rst_n), .DrawX(x2), .DrawY(y2),
    .FRAME_END(fe2), .LINE_END(le2), .VGA_HS(hs2), .VGA_VS(vs2),
    .VGA_BLANK_N(bl2), .FRAME_COUNT(fc2)
  );

  vga_timing_gen #(.FETCH_LATENCY(8)) dut8 (
    .VGA_CLK(clk), .RESET_N(rst_n), .DrawX(x8), .DrawY(y8),
    .FRAME_END(fe8), .LINE_END(le8), .VGA_HS(hs8), .VGA_VS(vs8),
    .VGA_BLANK_N(bl8), .FRAME_COUNT(fc8)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int         n;
    logic [9:0] x, y;
    logic       hs, vs, bl, le, fe, hs8, bl8;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_x(input int x, input int limit);
    bit found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (int'(x2) == x) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_x_reached", int'(found), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vi;
    int hs2_low, bl2_high, hs8_low;
    int fe_cnt, le_cnt, vs2_low, vs8_low;
    bit prev_fe;

    //          n    x        y      hs    vs    bl    le    fe    hs8   bl8
    tbl.push_back('{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1,   10'd1,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{2,   10'd2,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{7,   10'd7,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8,   10'd8,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{641, 10'd641, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{642, 10'd642, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{648, 10'd648, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{657, 10'd657, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{658, 10'd658, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{663, 10'd663, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{664, 10'd664, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{753, 10'd753, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{754, 10'd754, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{760, 10'd760, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{799, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{802, 10'd2,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{808, 10'd8,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

    // Reset held for 10 cycles.
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    step();
    chk("rst_x", int'(x2), 0);
    chk("rst_y", int'(y2), 0);
    chk("rst_fe", int'(fe2), 0);
    chk("rst_le", int'(le2), 0);
    chk("rst_hs", int'(hs2), 1);
    chk("rst_vs", int'(vs2), 1);
    chk("rst_bl", int'(bl2), 0);
    chk("rst_fc", int'(fc2), 0);
    chk("rst_bl8", int'(bl8), 0);
    chk("rst_hs8", int'(hs8), 1);

    // Release and walk through the first line plus a bit, checking the table.
    rst_n = 1'b1;
    vi = 0;
    hs2_low = 0; bl2_high = 0; hs8_low = 0;
    for (int n = 0; n <= 808; n++) begin
      if (n < 800) begin
        if (!hs2) hs2_low++;
        if (bl2)  bl2_high++;
        if (!hs8) hs8_low++;
      end
      if (vi < tbl.size() && tbl[vi].n == n) begin
        chk($sformatf("v%0d_x", n),   int'(x2),  int'(tbl[vi].x));
        chk($sformatf("v%0d_y", n),   int'(y2),  int'(tbl[vi].y));
        chk($sformatf("v%0d_hs", n),  int'(hs2), int'(tbl[vi].hs));
        chk($sformatf("v%0d_vs", n),  int'(vs2), int'(tbl[vi].vs));
        chk($sformatf("v%0d_bl", n),  int'(bl2), int'(tbl[vi].bl));
        chk($sformatf("v%0d_le", n),  int'(le2), int'(tbl[vi].le));
        chk($sformatf("v%0d_fe", n),  int'(fe2), int'(tbl[vi].fe));
        chk($sformatf("v%0d_hs8", n), int'(hs8), int'(tbl[vi].hs8));
        chk($sformatf("v%0d_bl8", n), int'(bl8), int'(tbl[vi].bl8));
        vi++;
      end
      step();
    end
    chk("table_all_applied", vi, tbl.size());
    chk("line0_hs_low_cycles", hs2_low, 96);
    chk("line0_blank_high_cycles", bl2_high, 640);
    chk("line0_hs8_low_cycles", hs8_low, 96);

    // Mid-frame reset at (300,200).
    wait_x(299, 1000);
    force dut.r_y = 10'd200;
    force dut8.r_y = 10'd200;
    step();
    release dut.r_y;
    release dut8.r_y;
    chk("mid_x", int'(x2), 300);
    chk("mid_y", int'(y2), 200);
    chk("mid_bl", int'(bl2), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_x", int'(x2), 0);
    chk("async_rst_y", int'(y2), 0);
    chk("async_rst_hs", int'(hs2), 1);
    chk("async_rst_bl", int'(bl2), 0);
    chk("async_rst_bl8", int'(bl8), 0);
    chk("async_rst_y8", int'(y8), 0);
    repeat (3) step();
    rst_n = 1'b1;
    chk("restart_x0", int'(x2), 0);
    step();
    chk("restart_x1", int'(x2), 1);
    chk("restart_y1", int'(y2), 0);
    chk("restart_bl_n1", int'(bl2), 0);
    step();
    chk("restart_bl_n2", int'(bl2), 1);

    // Jump to line 489 and run through the frame wrap.
    wait_x(5, 1000);
    force dut.r_y = 10'd489;
    force dut8.r_y = 10'd489;
    step();
    release dut.r_y;
    release dut8.r_y;
    chk("jump_x", int'(x2), 6);
    chk("jump_y", int'(y2), 489);
    fe_cnt = 0; le_cnt = 0; vs2_low = 0; vs8_low = 0; prev_fe = 1'b0;
    for (int i = 0; i < 29000; i++) begin
      if (prev_fe) begin
        chk("after_fe_x", int'(x2), 0);
        chk("after_fe_y", int'(y2), 0);
        chk("after_fe_fe", int'(fe2), 0);
      end
      if (fe2) begin
        fe_cnt++;
        chk("fe_x", int'(x2), 799);
        chk("fe_y", int'(y2), 524);
        chk("fe_le", int'(le2), 1);
      end
      if (le2)  le_cnt++;
      if (!vs2) vs2_low++;
      if (!vs8) vs8_low++;
      prev_fe = fe2;
      step();
    end
    chk("frame_end_pulses", fe_cnt, 1);
    chk("line_end_pulses", le_cnt, 36);
    chk("vs_low_cycles", vs2_low, 1600);
    chk("vs8_low_cycles", vs8_low, 1600);

`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count_one", int'(fc2), 1);
    // Preload the counter and line position just before a frame end.
    wait_x(700, 1000);
    force dut.r_y = 10'd524;
    force dut.r_frame_count = 16'hFFFF;
    step();
    release dut.r_y;
    release dut.r_frame_count;
    wait_x(799, 200);
    chk("fc_wrap_fe", int'(fe2), 1);
    chk("fc_before_wrap", int'(fc2), 65535);
    step();
    chk("fc_after_wrap", int'(fc2), 0);
`else
    chk("frame_count_tied", int'(fc2), 0);
    chk("frame_count8_tied", int'(fc8), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output. It sits directly upstream of the page controller and frame buffer read path. It produces the current pixel coordinates (DrawX/DrawY) and a one-cycle end-of-frame strobe, plus VGA_HS, VGA_VS and VGA_BLANK_N. The three video control outputs are delayed by a fixed number of cycles to cover frame buffer read latency, so pixel data and control reach the DAC aligned.

## Interface
- FETCH_LATENCY, default 2: lag in cycles of VGA_HS/VGA_VS/VGA_BLANK_N relative to DrawX/DrawY; legal range 1..8.
- H_TOTAL/V_TOTAL and porch/sync widths are not parameters; they are fixed constants in vga_timing_pkg.
- VGA_CLK  input  1  pixel clock, 25 MHz; all logic on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DrawX  output  10  current horizontal count, 0..799.
- DrawY  output  10  current vertical count, 0..524.
- FRAME_END  output  1  high for one cycle while (DrawX, DrawY) = (799, 524).
- LINE_END  output  1  high for one cycle while DrawX = 799.
- VGA_HS  output  1  horizontal sync, active low, delayed.
- VGA_VS  output  1  vertical sync, active low, delayed.
- VGA_BLANK_N  output  1  high in the visible region, delayed.
- FRAME_COUNT  output  16  completed-frame count (see Configuration).

## Operation
- Horizontal counter increments every cycle.
  - It wraps 799 -> 0.
  - On that wrap, the vertical counter increments and wraps 524 -> 0.
- Counter widths are 10 bits; values above 799/524 are unreachable.
- Decode is performed on the current counter values:
  - HS active when 656 <= x <= 751.
  - VS active when 490 <= y <= 491.
  - Visible region is x < 640 and y < 480.
- Decoded HS/VS/visible pass through a FETCH_LATENCY-deep register pipeline to the outputs.
  - The first stage is the decode register itself.
- FRAME_END and LINE_END are combinational from the counter registers and are not delayed.
  - They are aligned with DrawX/DrawY, so a consumer updating on FRAME_END changes state at the (799,524)->(0,0) edge.
- Reset values:
  - DrawX=0, DrawY=0, FRAME_END=0, LINE_END=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, FRAME_COUNT=0.
  - Every delay-pipeline stage resets to its inactive value (HS=1, VS=1, blank_n=0).
- Reset asserted mid-frame forces all of the above within the same cycle (asynchronous). Counting resumes from (0,0) on the first rising edge after deassertion.

## Timing
- Edge n after reset release: DrawX = n mod 800.
- Coordinate (x, y) appears on DrawX/DrawY in cycle t.
  - Its HS/VS/BLANK_N appear in cycle t+FETCH_LATENCY.
- With FETCH_LATENCY=2 after reset:
  - VGA_HS first goes low in the cycle where DrawX=658.
  - VGA_HS returns high where DrawX=754.
- The first VGA_BLANK_N high occurs FETCH_LATENCY cycles after reset release.
  - Before then the pipeline holds reset values, so no stale visible pixel is emitted.
- FRAME_END period: exactly 420000 cycles. LINE_END period: 800 cycles.

## Configuration
- Macro VGA_FRAME_COUNT_EN.
- Defined:
  - FRAME_COUNT increments by 1 on each rising edge where FRAME_END is high.
  - It wraps 65535 -> 0.
- Undefined:
  - No counter is implemented and FRAME_COUNT is tied to 0.
  - The port is still present, so instantiations are unchanged.

## Structure
- vga_timing_pkg holds:
  - constants H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800;
  - constants V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525;
  - a packed struct vga_ctrl_t {hs_n, vs_n, blank_n}.
- One sub-module, sync_delay_line: parameterised depth, vga_ctrl_t in/out, reset value input, async active-low reset. It implements the FETCH_LATENCY pipeline.

## Test plan
- Reset held 10 cycles, then released -> outputs match the reset values above; DrawX=1 after the first edge and DrawX=799 after the 799th edge.
- Run 1 line with FETCH_LATENCY=2 -> VGA_HS low for exactly 96 cycles, in cycles where DrawX=658..753; VGA_BLANK_N high for 640 cycles starting where DrawX=2 (y=0).
- Run 1 full frame -> FRAME_END high once, in the cycle with (799,524); the next cycle shows (0,0); VGA_VS low for 1600 cycles.
- Assert RESET_N mid-frame at (300,200) -> DrawX/DrawY read 0 before the next edge and VGA_HS=1; after release, counting restarts from (0,0).
- Build with VGA_FRAME_COUNT_EN and run 3 frames -> FRAME_COUNT = 3; preload near wrap via force, 65535 -> 0. Build without the macro -> FRAME_COUNT stays 0.
- FETCH_LATENCY=8 -> VGA_HS falls where DrawX=664; BLANK_N stays low for the first 8 cycles after reset.
